bram_rr_arbiter: RTL and testbench

- Shares the single-port user BRAM (one EN0/WE0/A0/Di0/Do0 port, fixed DELAYS-cycle access) between two requesters.
- Requester 0 is the Wishbone slave path in the user project wrapper, decoded at 0x380x_xxxx. Requester 1 is the UART RX/TX buffer engine.
- Round-robin, non-preemptive arbitration. Grant is held until the access completes.
- The block owns the access-delay counter and the ready pulse; requesters never drive the BRAM directly.

---
 rtl/bram_rr_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_bram_rr_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_rr_arbiter.sv
// Round-robin, non-preemptive arbiter that shares one single-port BRAM between
// the Wishbone slave path (requester 0) and the UART buffer engine (requester 1).
module bram_rr_arbiter #(
  parameter int unsigned DELAYS = 10,
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_valid,
  input  logic [3:0]    r0_wstrb,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ready,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_valid,
  input  logic [3:0]    r1_wstrb,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ready,
  output logic [DW-1:0] r1_rdata,
  output logic          bram_en,
  output logic [3:0]    bram_we,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_di,
  input  logic [DW-1:0] bram_do,
  output logic [1:0]    grant,
  output logic          busy
);

  localparam logic [15:0] DELAYS_C = 16'(DELAYS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          own_valid_s;
  logic [3:0]    own_wstrb_s;
  logic [AW-1:0] own_addr_s;
  logic [DW-1:0] own_wdata_s;
  logic [1:0]    own_grant_s;

  // Route the current owner's request fields onto a common set of wires
  always_comb begin
    if (owner_q) begin
      own_valid_s = r1_valid;
      own_wstrb_s = r1_wstrb;
      own_addr_s  = r1_addr;
      own_wdata_s = r1_wdata;
      own_grant_s = 2'b10;
    end else begin
      own_valid_s = r0_valid;
      own_wstrb_s = r0_wstrb;
      own_addr_s  = r0_addr;
      own_wdata_s = r0_wdata;
      own_grant_s = 2'b01;
    end
  end

  // Next-state logic: arbitration, access counting, capture and abort
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    rdata_d      = rdata_q;
    case (state_q)
      ST_IDLE: begin
        // On a tie the requester that did not win last time gets the bus.
        if (r0_valid && r1_valid) begin
          owner_d = ~last_grant_q;
          cnt_d   = 16'd0;
          state_d = ST_ACCESS;
        end else if (r0_valid) begin
          owner_d = 1'b0;
          cnt_d   = 16'd0;
          state_d = ST_ACCESS;
        end else if (r1_valid) begin
          owner_d = 1'b1;
          cnt_d   = 16'd0;
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // A withdrawn request ends the access without a ready and leaves
        // the round-robin history untouched.
        if (!own_valid_s) begin
          cnt_d   = 16'd0;
          state_d = ST_IDLE;
        end else if (cnt_q == DELAYS_C) begin
          rdata_d = bram_do;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + 16'd1;
          state_d = ST_ACCESS;
        end
      end
      ST_DONE: begin
        last_grant_d = owner_q;
        cnt_d        = 16'd0;
        state_d      = ST_IDLE;
      end
      default: begin
        cnt_d   = 16'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the current state and owner
  always_comb begin
    bram_en   = 1'b0;
    bram_we   = 4'd0;
    bram_addr = {AW{1'b0}};
    bram_di   = {DW{1'b0}};
    grant     = 2'b00;
    busy      = 1'b0;
    r0_ready  = 1'b0;
    r1_ready  = 1'b0;
    r0_rdata  = {DW{1'b0}};
    r1_rdata  = {DW{1'b0}};
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_ACCESS: begin
        bram_en   = 1'b1;
        bram_addr = own_addr_s;
        bram_di   = own_wdata_s;
        grant     = own_grant_s;
        busy      = 1'b1;
        // Strobes only on the first access cycle so a write lands once.
        if (cnt_q == 16'd0) begin
          bram_we = own_wstrb_s;
        end else begin
          bram_we = 4'd0;
        end
      end
      ST_DONE: begin
        grant = own_grant_s;
        busy  = 1'b1;
        if (owner_q) begin
          r1_ready = 1'b1;
          r1_rdata = rdata_q;
        end else begin
          r0_ready = 1'b1;
          r0_rdata = rdata_q;
        end
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rdata_q      <= {DW{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Self-checking bench for bram_rr_arbiter: vector table, directed corner
// sequences, and randomized traffic against a transaction-level model.
module tb_bram_rr_arbiter;
  localparam int D = 10;

  logic clk;
  logic rst_n;
  logic        r0_valid, r1_valid, r0_ready, r1_ready;
  logic [3:0]  r0_wstrb, r1_wstrb, bram_we;
  logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata, r0_rdata, r1_rdata;
  logic        bram_en, busy;
  logic [31:0] bram_addr, bram_di, bram_do;
  logic [1:0]  grant;

  logic        z_r0_valid, z_r1_valid, z_r0_ready, z_r1_ready;
  logic [3:0]  z_r0_wstrb, z_r1_wstrb, z_bram_we;
  logic [31:0] z_r0_addr, z_r1_addr, z_r0_wdata, z_r1_wdata, z_r0_rdata, z_r1_rdata;
  logic        z_bram_en, z_busy;
  logic [31:0] z_bram_addr, z_bram_di, z_bram_do;
  logic [1:0]  z_grant;

  logic [31:0] mem  [0:15];
  logic [31:0] mem0 [0:15];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  bram_rr_arbiter #(.DELAYS(D), .AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_wstrb(r0_wstrb), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_wstrb(r1_wstrb), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_rdata(r1_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_di(bram_di),
    .bram_do(bram_do), .grant(grant), .busy(busy)
  );

  bram_rr_arbiter #(.DELAYS(0), .AW(32), .DW(32)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(z_r0_valid), .r0_wstrb(z_r0_wstrb), .r0_addr(z_r0_addr), .r0_wdata(z_r0_wdata),
    .r0_ready(z_r0_ready), .r0_rdata(z_r0_rdata),
    .r1_valid(z_r1_valid), .r1_wstrb(z_r1_wstrb), .r1_addr(z_r1_addr), .r1_wdata(z_r1_wdata),
    .r1_ready(z_r1_ready), .r1_rdata(z_r1_rdata),
    .bram_en(z_bram_en), .bram_we(z_bram_we), .bram_addr(z_bram_addr), .bram_di(z_bram_di),
    .bram_do(z_bram_do), .grant(z_grant), .busy(z_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // BRAM models: asynchronous read, byte-enabled synchronous write
  assign bram_do   = mem[bram_addr[5:2]];
  assign z_bram_do = mem0[z_bram_addr[5:2]];
  always @(posedge clk) begin
    if (bram_en && bram_we != 4'd0) mem[bram_addr[5:2]] <= merge(mem[bram_addr[5:2]], bram_we, bram_di);
    if (z_bram_en && z_bram_we != 4'd0) mem0[z_bram_addr[5:2]] <= merge(mem0[z_bram_addr[5:2]], z_bram_we, z_bram_di);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input int i, input logic v, input logic [3:0] ws,
                       input logic [31:0] a, input logic [31:0] wd);
    if (i == 1) begin
      r1_valid = v; r1_wstrb = ws; r1_addr = a; r1_wdata = wd;
    end else begin
      r0_valid = v; r0_wstrb = ws; r0_addr = a; r0_wdata = wd;
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {bram_en, bram_we, grant, busy, r0_ready, r1_ready}, 32'd0);
    check(name, bram_addr | bram_di | r0_rdata | r1_rdata, 32'd0);
  endtask

  // One isolated transaction; observed latency counts edges from the edge
  // where valid is first sampled to the sample showing ready.
  task automatic xact(input int req, input logic [3:0] ws, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output int lat,
                      output int en_n, output int we_n, output int other_n);
    int t0;
    logic mine, other;
    drive(req, 1'b1, ws, a, wd);
    t0 = cyc + 1;
    en_n = 0; we_n = 0; other_n = 0; lat = -1; rd = 32'd0;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      tick();
      mine  = (req == 1) ? r1_ready : r0_ready;
      other = (req == 1) ? r0_ready : r1_ready;
      if (bram_en) en_n++;
      if (bram_we != 4'd0) we_n++;
      if (other) other_n++;
      if (mine) begin
        lat = cyc - t0;
        rd  = (req == 1) ? r1_rdata : r0_rdata;
      end
    end
    drive(req, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    check("ready_single_pulse", {30'd0, r1_ready, r0_ready}, 32'd0);
  endtask

  typedef struct {
    int          req;
    logic [3:0]  ws;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  logic [31:0] rd, shadow [0:7];
  logic [7:0]  known;
  logic [1:0]  exp_g;
  logic        p0, p1, act_r, exp_r, m_active;
  int          lat, en_n, we_n, other_n, t0, prev, nready, ta, cnt_r0, cnt_r1;
  int          m_win, m_done, m_free, m_last, w, n_done;
  int          req_edge [2], gap [2];
  logic        pend [2];
  logic [3:0]  op_ws [2];
  logic [31:0] op_addr [2], op_wd [2];
  logic [2:0]  idx;

  initial begin
    vecs[0] = '{0, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1] = '{0, 4'h0, 32'h3800_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{1, 4'hF, 32'h3800_0004, 32'h1234_5678, 1'b0, 32'h0};
    vecs[3] = '{0, 4'h0, 32'h3800_0004, 32'h0,         1'b1, 32'h1234_5678};
    vecs[4] = '{1, 4'hF, 32'h3800_0008, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[5] = '{0, 4'h2, 32'h3800_0008, 32'h0000_AB00, 1'b0, 32'h0};
    vecs[6] = '{1, 4'h0, 32'h3800_0008, 32'h0,         1'b1, 32'hFFFF_ABFF};
    vecs[7] = '{0, 4'h5, 32'h3800_0004, 32'h1122_3344, 1'b0, 32'h0};
    vecs[8] = '{1, 4'h0, 32'h3800_0004, 32'h0,         1'b1, 32'h1222_5644};

    rst_n = 1'b0;
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
    z_r0_valid = 1'b0; z_r0_wstrb = 4'd0; z_r0_addr = 32'd0; z_r0_wdata = 32'd0;
    z_r1_valid = 1'b0; z_r1_wstrb = 4'd0; z_r1_addr = 32'd0; z_r1_wdata = 32'd0;
    tick();
    tick();
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    tick();

    // Vector table: isolated transactions
    for (int v = 0; v < 9; v++) begin
      xact(vecs[v].req, vecs[v].ws, vecs[v].addr, vecs[v].wd, rd, lat, en_n, we_n, other_n);
      check("tbl_latency", lat, D + 1);
      check("tbl_en_cycles", en_n, D + 1);
      check("tbl_we_cycles", we_n, (vecs[v].ws != 4'd0) ? 1 : 0);
      check("tbl_other_ready", other_n, 0);
      if (vecs[v].chk) check("tbl_rdata", rd, vecs[v].exp);
    end

    // Continuous contention from reset: strict alternation, fixed spacing
    rst_n = 1'b0;
    drive(0, 1'b1, 4'd0, 32'h3800_0010, 32'd0);
    drive(1, 1'b1, 4'd0, 32'h3800_0004, 32'd0);
    tick();
    check_all_zero("reset_with_valid");
    rst_n = 1'b1;
    t0 = cyc + 1;
    nready = 0;
    prev = 0;
    for (int k = 0; k < 8 * (D + 3) + 20 && nready < 8; k++) begin
      tick();
      if (r0_ready || r1_ready) begin
        check("rr_both_ready", {31'd0, r0_ready && r1_ready}, 32'd0);
        check("rr_owner", {31'd0, r1_ready}, nready % 2);
        check("rr_rdata", r1_ready ? r1_rdata : r0_rdata,
              r1_ready ? 32'h1222_5644 : 32'hDEAD_BEEF);
        if (nready == 0) check("rr_first_latency", cyc - t0, D + 1);
        else             check("rr_spacing", cyc - prev, D + 3);
        prev = cyc;
        nready++;
      end
    end
    check("rr_count", nready, 8);
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    tick();

    // Abort by requester 0 at cnt=3 with requester 1 waiting, then reset mid-access
    cnt_r0 = 0;
    cnt_r1 = 0;
    drive(0, 1'b1, 4'd0, 32'h3800_0010, 32'd0);
    ta = cyc + 1;
    tick();
    check("abort_grant0", {30'd0, grant}, 32'd1);
    drive(1, 1'b1, 4'd0, 32'h3800_0004, 32'd0);
    while (cyc < ta + 3) begin
      tick();
      if (r0_ready) cnt_r0++;
    end
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    check("abort_idle_grant", {30'd0, grant}, 32'd0);
    check("abort_idle_busy", {31'd0, busy}, 32'd0);
    if (r0_ready) cnt_r0++;
    tick();
    check("abort_grant1", {30'd0, grant}, 32'd2);
    check("abort_addr1", bram_addr, 32'h3800_0004);
    tick();
    tick();
    if (r1_ready) cnt_r1++;
    rst_n = 1'b0;
    tick();
    check_all_zero("midaccess_reset");
    drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < D + 6; k++) begin
      tick();
      if (r0_ready) cnt_r0++;
      if (r1_ready) cnt_r1++;
    end
    check("abort_no_r0_ready", cnt_r0, 0);
    check("reset_no_r1_ready", cnt_r1, 0);

    // DELAYS=0 instance: write then read by requester 1
    for (int p = 0; p < 2; p++) begin
      z_r1_valid = 1'b1;
      z_r1_addr  = 32'h3800_0020;
      z_r1_wstrb = (p == 0) ? 4'hF : 4'h0;
      z_r1_wdata = 32'hCAFE_F00D;
      t0 = cyc + 1;
      en_n = 0; we_n = 0; lat = -1; rd = 32'd0;
      for (int k = 0; k < 10 && lat < 0; k++) begin
        tick();
        if (z_bram_en) en_n++;
        if (z_bram_we != 4'd0) we_n++;
        if (z_r1_ready) begin
          lat = cyc - t0;
          rd  = z_r1_rdata;
        end
      end
      z_r1_valid = 1'b0;
      tick();
      check("d0_latency", lat, 1);
      check("d0_en_cycles", en_n, 1);
      check("d0_we_cycles", we_n, (p == 0) ? 1 : 0);
      if (p == 1) check("d0_rdata", rd, 32'hCAFE_F00D);
    end

    // Randomized traffic against a transaction-level model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_free = cyc + 1;
    m_last = 1;
    m_active = 1'b0;
    m_win = 0;
    m_done = 0;
    n_done = 0;
    known = 8'd0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0;
      gap[i] = $urandom_range(0, 3);
      req_edge[i] = 0;
    end
    for (int k = 0; k < 1500; k++) begin
      tick();
      if (!m_active && cyc >= m_free) begin
        p0 = pend[0] && (req_edge[0] <= cyc);
        p1 = pend[1] && (req_edge[1] <= cyc);
        if (p0 || p1) begin
          m_active = 1'b1;
          m_win = (p0 && p1) ? 1 - m_last : (p1 ? 1 : 0);
          m_done = cyc + D + 1;
        end
      end
      exp_g = m_active ? ((m_win == 1) ? 2'b10 : 2'b01) : 2'b00;
      check("rnd_grant", {30'd0, grant}, {30'd0, exp_g});
      check("rnd_busy", {31'd0, busy}, {31'd0, exp_g != 2'b00});
      for (int i = 0; i < 2; i++) begin
        act_r = (i == 1) ? r1_ready : r0_ready;
        exp_r = m_active && (m_win == i) && (cyc == m_done);
        if (act_r || exp_r) check("rnd_ready", {31'd0, act_r}, {31'd0, exp_r});
      end
      if (m_active && cyc == m_done) begin
        w = m_win;
        idx = op_addr[w][4:2];
        if (op_ws[w] == 4'd0) begin
          if (known[idx]) check("rnd_rdata", (w == 1) ? r1_rdata : r0_rdata, shadow[idx]);
        end else begin
          shadow[idx] = merge(shadow[idx], op_ws[w], op_wd[w]);
          if (op_ws[w] == 4'hF) known[idx] = 1'b1;
        end
        check("rnd_nonowner_rdata", (w == 1) ? r0_rdata : r1_rdata, 32'd0);
        m_active = 1'b0;
        m_free = cyc + 2;
        m_last = w;
        pend[w] = 1'b0;
        drive(w, 1'b0, 4'd0, 32'd0, 32'd0);
        gap[w] = $urandom_range(1, 5);
        n_done++;
      end
      for (int i = 0; i < 2; i++) begin
        if (!pend[i]) begin
          if (gap[i] == 0) begin
            op_ws[i]   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            op_addr[i] = 32'h3800_0000 + 32'($urandom_range(0, 7)) * 32'd4;
            op_wd[i]   = $urandom;
            drive(i, 1'b1, op_ws[i], op_addr[i], op_wd[i]);
            req_edge[i] = cyc + 1;
            pend[i] = 1'b1;
          end else begin
            gap[i]--;
          end
        end
      end
    end
    check("rnd_progress", {31'd0, n_done >= 40}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
